// File: rtl/pwm_demodulator_pkg.sv
// ---------------------------------------------------------------------------
// pwm_demodulator_pkg
// Shared definitions for the PWM demodulator:
//   - FSM state encodings ST_IDLE / ST_RUNNING
//   - AM_* parameter defaults shared with the AM PWM modulator
//   - cnt_width(): counter width helper that never returns 0
// ---------------------------------------------------------------------------
package pwm_demodulator_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  localparam int AM_CLKS_PER_PWM_STEP_DEF   = 1;
  localparam int AM_PWM_STEP_PER_SAMPLE_DEF = 255;
  localparam int AM_BITS_PER_SAMPLE_DEF     = 8;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_demodulator_pwm_in_sync.sv
// ---------------------------------------------------------------------------
// pwm_in_sync
// Brings the asynchronous PWM pin into the clk domain and detects the rising
// edge that opens each symbol.
//
// Optional build macro: PWM_DEMOD_GLITCH_FILTER_EN
//   defined   : 3-sample majority filter after the 2-flop synchroniser,
//               pin-to-o_pwm_s latency 3 clk, single-clk glitches rejected.
//   undefined : o_pwm_s is the raw synchroniser output, latency 2 clk.
//
// Ports
//   i_clk    in  system clock
//   i_rst_n  in  asynchronous active-low reset
//   i_pwm    in  PWM pin, asynchronous to i_clk
//   o_pwm_s  out synchronised (optionally filtered) PWM level
//   o_rise   out one-cycle pulse: o_pwm_s=1 while its previous value was 0
// ---------------------------------------------------------------------------
module pwm_in_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pwm,
  output logic o_pwm_s,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_pwm_s;

  // Stage: two-flop synchroniser
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
  logic r_sync3;
  logic r_sync4;

  // Stage: three-tap history for the majority vote
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync3 <= 1'b0;
      r_sync4 <= 1'b0;
    end else begin
      r_sync3 <= r_sync2;
      r_sync4 <= r_sync3;
    end
  end

  // Two of the last three synchronised samples must agree, so a level change
  // shows one clk later and a lone one-clk pulse never reaches the output.
  assign w_pwm_s = (r_sync2 & r_sync3) | (r_sync2 & r_sync4) | (r_sync3 & r_sync4);
`else
  assign w_pwm_s = r_sync2;
`endif

  // Stage: edge-detect history
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_pwm_s;
    end
  end

  assign o_pwm_s = w_pwm_s;
  assign o_rise  = w_pwm_s & ~r_prev;

endmodule

// File: rtl/pwm_demodulator.sv
// ---------------------------------------------------------------------------
// pwm_demodulator
// Receive side of the AM PWM link: recovers one AM_BITS_PER_SAMPLE-bit sample
// per symbol of AM_PWM_STEP_PER_SAMPLE PWM steps by counting high steps, and
// pushes each sample into a downstream FIFO write port.
//
// Optional build macro: PWM_DEMOD_GLITCH_FILTER_EN (see pwm_in_sync).
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   enable    in   1 = demodulate, 0 = drop to ST_IDLE, no writes
//   pwm_in    in   PWM stream, asynchronous to clk
//   full      in   downstream FIFO full
//   sample    out  recovered sample, meaningful while write=1
//   write     out  one-cycle FIFO write strobe
//   locked    out  1 while in ST_RUNNING
//   overflow  out  sticky: a sample was dropped because full=1
//   resync    out  sticky: framing realigned mid-symbol
// ---------------------------------------------------------------------------
module pwm_demodulator
  import pwm_demodulator_pkg::*;
#(
  parameter int AM_CLKS_PER_PWM_STEP   = AM_CLKS_PER_PWM_STEP_DEF,
  parameter int AM_PWM_STEP_PER_SAMPLE = AM_PWM_STEP_PER_SAMPLE_DEF,
  parameter int AM_BITS_PER_SAMPLE     = AM_BITS_PER_SAMPLE_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          pwm_in,
  input  logic                          full,
  output logic [AM_BITS_PER_SAMPLE-1:0] sample,
  output logic                          write,
  output logic                          locked,
  output logic                          overflow,
  output logic                          resync
);

  localparam int CLK_W  = cnt_width(AM_CLKS_PER_PWM_STEP);
  localparam int STEP_W = cnt_width(AM_PWM_STEP_PER_SAMPLE);
  localparam int W      = AM_BITS_PER_SAMPLE;

  localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(AM_CLKS_PER_PWM_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(AM_PWM_STEP_PER_SAMPLE - 1);
  localparam logic [W-1:0]      HIGH_MAX  = '1;

  // High-step counter increment that sticks at all-ones.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] cnt, input logic inc);
    if (inc && (cnt != HIGH_MAX)) begin
      return cnt + W'(1);
    end
    return cnt;
  endfunction

  logic              w_pwm_s;
  logic              w_rise;
  logic              w_tick;
  logic              w_sym_end;
  logic              w_misalign;
  logic [W-1:0]      w_high_next;
  logic [CLK_W-1:0]  w_clk_next;

  state_t            r_state;
  logic              r_pwm_d;
  logic [CLK_W-1:0]  r_clk_cnt;
  logic [STEP_W-1:0] r_step_idx;
  logic [W-1:0]      r_high_cnt;
  logic [W-1:0]      r_sample;
  logic              r_write;
  logic              r_locked;
  logic              r_overflow;
  logic              r_resync;

  pwm_in_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_pwm   (pwm_in),
    .o_pwm_s (w_pwm_s),
    .o_rise  (w_rise)
  );

  // Stage: one-cycle delay of the synchronised level. A symbol opens on the
  // rise cycle but its first tick comes a cycle later, so each tick counts the
  // level of the cycle before it; that keeps the opening high step in its own
  // symbol and leaves the next symbol's rise outside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwm_d <= 1'b0;
    end else begin
      r_pwm_d <= w_pwm_s;
    end
  end

  // Prescaler value 0 is the tick; it is forced to 0 on symbol start so the
  // first tick lands on the following cycle.
  assign w_tick      = (r_state == ST_RUNNING) && (r_clk_cnt == '0);
  assign w_sym_end   = w_tick && (r_step_idx == STEP_LAST);
  // A rise landing on the end tick is the normal opening of the next symbol;
  // a rise at step 0 is on time; anything else means framing has slipped.
  assign w_misalign  = w_rise && (r_step_idx != '0) && !w_sym_end;
  assign w_high_next = sat_inc(r_high_cnt, r_pwm_d);
  assign w_clk_next  = (r_clk_cnt == CLK_LAST) ? '0 : r_clk_cnt + CLK_W'(1);

  // Stage: framing FSM, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_clk_cnt  <= '0;
      r_step_idx <= '0;
      r_high_cnt <= '0;
      r_sample   <= '0;
      r_write    <= 1'b0;
      r_locked   <= 1'b0;
      r_overflow <= 1'b0;
      r_resync   <= 1'b0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clk_cnt  <= '0;
          r_step_idx <= '0;
          r_high_cnt <= '0;
          if (enable && w_rise) begin
            r_state  <= ST_RUNNING;
            r_locked <= 1'b1;
          end
        end

        ST_RUNNING: begin
          if (!enable) begin
            r_state    <= ST_IDLE;
            r_locked   <= 1'b0;
            r_clk_cnt  <= '0;
            r_step_idx <= '0;
            r_high_cnt <= '0;
          end else if (w_sym_end) begin
            // The final step is folded into the written value; the next
            // symbol starts immediately whether or not a rise shows up.
            if (full) begin
              r_overflow <= 1'b1;
            end else begin
              r_write  <= 1'b1;
              r_sample <= w_high_next;
            end
            r_high_cnt <= '0;
            r_step_idx <= '0;
            r_clk_cnt  <= w_rise ? '0 : w_clk_next;
          end else if (w_misalign) begin
            // Drop the partial symbol and reframe on this edge.
            r_resync   <= 1'b1;
            r_high_cnt <= '0;
            r_step_idx <= '0;
            r_clk_cnt  <= '0;
          end else begin
            // An on-time rise between ticks re-phases the prescaler.
            r_clk_cnt <= (w_rise && !w_tick) ? '0 : w_clk_next;
            if (w_tick) begin
              r_high_cnt <= w_high_next;
              r_step_idx <= r_step_idx + STEP_W'(1);
            end
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign sample   = r_sample;
  assign write    = r_write;
  assign locked   = r_locked;
  assign overflow = r_overflow;
  assign resync   = r_resync;

endmodule

// File: tb/tb_pwm_demodulator.sv
// ---------------------------------------------------------------------------
// tb_pwm_demodulator
// Drives PWM symbols shaped like the AM modulator output (v high steps then
// low, 255 steps, one clk per step) and checks the FIFO writes and status
// flags of pwm_demodulator at default parameters.
// ---------------------------------------------------------------------------
module tb_pwm_demodulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       pwm_in = 1'b0;
  logic       full = 1'b0;
  logic [7:0] sample;
  logic       write;
  logic       locked;
  logic       overflow;
  logic       resync;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  pwm_demodulator dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .pwm_in   (pwm_in),
    .full     (full),
    .sample   (sample),
    .write    (write),
    .locked   (locked),
    .overflow (overflow),
    .resync   (resync)
  );

  always #5 clk = ~clk;

  // Monitor: every write must match the oldest expected sample.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (write) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write sample=%02h expected_none", sample);
        end else begin
          e = exp_q.pop_front();
          if (sample !== e) begin
            n_err++;
            $display("FAIL write_sample got=%02h want=%02h", sample, e);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic send_steps(input int v, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      pwm_in = (i < v);
    end
  endtask

  // full changes a few steps in, after the previous symbol's end decision.
  task automatic send_sym(input int v, input logic f, input logic expect_wr);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      pwm_in = (i < v);
      if (i == 5) full = f;
    end
    if (expect_wr) exp_q.push_back(8'(v));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 700) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic stop_rx();
    enable = 1'b0;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_write", write, 0);
    check("rst_locked", locked, 0);
    check("rst_overflow", overflow, 0);
    check("rst_resync", resync, 0);
    check("rst_sample", sample, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 1: loopback sequence behind a 0x10 lock symbol
    enable = 1'b1;
    send_sym(8'h10, 1'b0, 1'b1);
    send_sym(8'h00, 1'b0, 1'b1);
    send_sym(8'h01, 1'b0, 1'b1);
    send_sym(8'h80, 1'b0, 1'b1);
    send_sym(8'hFE, 1'b0, 1'b1);
    send_sym(8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    pwm_in = 1'b0;
    drain();
    check("t1_locked", locked, 1);
    check("t1_resync", resync, 0);
    check("t1_overflow", overflow, 0);
    stop_rx();
    check("t1_unlocked", locked, 0);

    // 2: one symbol dropped on full
    enable = 1'b1;
    send_sym(8'h40, 1'b0, 1'b1);
    send_sym(8'h40, 1'b1, 1'b0);
    send_sym(8'h40, 1'b0, 1'b1);
    @(negedge clk);
    pwm_in = 1'b0;
    drain();
    check("t2_overflow", overflow, 1);
    check("t2_resync", resync, 0);
    stop_rx();

    // 3: early rising edge at step 100 reframes
    enable = 1'b1;
    send_sym(8'h20, 1'b0, 1'b1);
    send_steps(8'h20, 0, 99);
    send_sym(8'h20, 1'b0, 1'b1);
    send_sym(8'h20, 1'b0, 1'b1);
    @(negedge clk);
    pwm_in = 1'b0;
    drain();
    check("t3_resync", resync, 1);
    check("t3_locked", locked, 1);
    stop_rx();

    // 4: enable dropped at step 50, then relock
    enable = 1'b1;
    send_sym(8'h30, 1'b0, 1'b1);
    send_steps(8'h30, 0, 50);
    check("t4_locked_before", locked, 1);
    enable = 1'b0;
    @(negedge clk);
    pwm_in = 1'b0;
    check("t4_locked_drop", locked, 0);
    repeat (20) @(negedge clk);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    send_sym(8'h30, 1'b0, 1'b1);
    send_sym(8'h30, 1'b0, 1'b1);
    @(negedge clk);
    pwm_in = 1'b0;
    drain();
    check("t4_relocked", locked, 1);
    stop_rx();

    // 5: asynchronous reset mid-symbol
    enable = 1'b1;
    send_sym(8'h50, 1'b0, 1'b1);
    send_steps(8'h50, 0, 80);
    #2;
    rst = 1'b0;
    #1;
    check("t5_write", write, 0);
    check("t5_locked", locked, 0);
    check("t5_overflow", overflow, 0);
    check("t5_resync", resync, 0);
    check("t5_sample", sample, 0);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_sym(8'h50, 1'b0, 1'b1);
    send_sym(8'h50, 1'b0, 1'b1);
    @(negedge clk);
    pwm_in = 1'b0;
    drain();
    stop_rx();

    // 6: one-clk glitch inside a 0x00 symbol
    enable = 1'b1;
    send_sym(8'h07, 1'b0, 1'b1);
    send_steps(8'h00, 0, 99);
    @(negedge clk);
    pwm_in = 1'b1;
    send_steps(8'h00, 101, 254);
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    exp_q.push_back(8'h00);
`endif
    send_sym(8'h07, 1'b0, 1'b1);
    @(negedge clk);
    pwm_in = 1'b0;
    drain();
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    check("t6_resync", resync, 0);
`else
    check("t6_resync", resync, 1);
`endif
    stop_rx();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
